crack_scheduler: RTL and testbench

Work-queue scheduler sitting between the password cracker top level and its array of brute-force processing elements (PEs). It splits the first-character index space of the charset into fixed-size slices, hands each slice to an idle PE, and collects match and finish reports. It stops every PE on the first match and reports the cracked password, the winning PE and the elapsed clock count. Both outcomes, match and exhaustion, end in a sticky `done`.

---
 rtl/crack_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_crack_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/crack_scheduler.sv
// crack_scheduler: splits the first-character index space into slices,
// hands them to idle PEs, stops all PEs on the first match and reports
// the winner, or flags exhaustion once every slice has retired.

// One PE slot: busy bit, registered dispatch pulse and held slice bounds.
module crack_lane (
    input  logic       clk_i,
    input  logic       rst_i,      // active-low async
    input  logic       clr_i,      // job start: forget previous busy state
    input  logic       disp_i,     // dispatch this slot this cycle
    input  logic       retire_i,   // qualified pe_done for this slot
    input  logic [5:0] from_i,
    input  logic [5:0] to_i,
    output logic       busy_o,
    output logic       start_o,
    output logic [5:0] from_o,
    output logic [5:0] to_o
);
    logic       busy_q, start_q;
    logic [5:0] from_q, to_q;

    // Busy bit set on dispatch, cleared on retire; bounds held until next dispatch.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            from_q  <= '0;
            to_q    <= '0;
        end else begin
            start_q <= disp_i;
            if (clr_i)         busy_q <= 1'b0;
            else if (disp_i)   busy_q <= 1'b1;
            else if (retire_i) busy_q <= 1'b0;
            if (disp_i) begin
                from_q <= from_i;
                to_q   <= to_i;
            end
        end
    end

    assign busy_o  = busy_q;
    assign start_o = start_q;
    assign from_o  = from_q;
    assign to_o    = to_q;
endmodule

module crack_scheduler #(
    parameter int NUM_PE  = 9,
    parameter int CHARSET = 36,
    parameter int SLICE   = 4,
    parameter int PWD_W   = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,      // active-low async
    input  logic                      start_i,
    input  logic [PWD_W-1:0]          password_to_crack_i,
    output logic [PWD_W-1:0]          pe_target_o,
    output logic [NUM_PE-1:0]         pe_start_o,
    output logic [6*NUM_PE-1:0]       pe_from_o,
    output logic [6*NUM_PE-1:0]       pe_to_o,
    output logic                      pe_abort_o,
    input  logic [NUM_PE-1:0]         pe_found_i,
    input  logic [NUM_PE-1:0]         pe_done_i,
    input  logic [PWD_W*NUM_PE-1:0]   pe_guess_i,
    output logic                      busy_o,
    output logic                      found_o,
    output logic                      done_o,
    output logic [PWD_W-1:0]          cracked_o,
    output logic [3:0]                winner_pe_o,
    output logic [20:0]               cycle_count_o
);
    localparam int NSLICE = (CHARSET + SLICE - 1) / SLICE;

    typedef enum logic [1:0] {IDLE, RUN, FOUND, EXHAUSTED} state_t;
    typedef struct packed {
        logic [5:0] from;
        logic [5:0] to;
    } slice_t;

    state_t                        state_q, state_d;
    logic [6:0]                    ns_q, ns_d;
    logic [PWD_W-1:0]              target_q, target_d;
    logic                          found_q, found_d, done_q, done_d;
    logic [PWD_W-1:0]              cracked_q, cracked_d;
    logic [3:0]                    winner_q, winner_d;
    logic [20:0]                   cnt_q, cnt_d;
    logic                          abort_q, abort_d;

    logic [NUM_PE-1:0][PWD_W-1:0]  guess_a;
    logic [NUM_PE-1:0][5:0]        from_a, to_a;
    logic [NUM_PE-1:0]             busy_v, start_v, disp_v, retire_v;
    logic [NUM_PE-1:0]             hit_v, free_oh;
    logic                          clr;
    logic [3:0]                    win_idx;
    logic [PWD_W-1:0]              win_guess;
    logic [12:0]                   base, last;
    slice_t                        nxt;

    assign guess_a = pe_guess_i;

    // Bounds of the slice that would go out this cycle, clipped to the charset.
    always_comb begin
        base     = 13'(ns_q) * 13'(SLICE);
        last     = base + 13'(SLICE - 1);
        if (last > 13'(CHARSET - 1)) last = 13'(CHARSET - 1);
        nxt.from = base[5:0];
        nxt.to   = last[5:0];
    end

    // Lowest-index match among busy PEs and lowest-index idle PE.
    always_comb begin
        hit_v     = pe_found_i & busy_v;
        win_idx   = '0;
        win_guess = '0;
        free_oh   = '0;
        for (int i = NUM_PE - 1; i >= 0; i--) begin
            if (hit_v[i]) begin
                win_idx   = 4'(i);
                win_guess = guess_a[i];
            end
            if (!busy_v[i]) begin
                free_oh    = '0;
                free_oh[i] = 1'b1;
            end
        end
    end

    // Next-state, job setup, dispatch, match and exhaustion decisions.
    always_comb begin
        state_d   = state_q;
        ns_d      = ns_q;
        target_d  = target_q;
        found_d   = found_q;
        done_d    = done_q;
        cracked_d = cracked_q;
        winner_d  = winner_q;
        cnt_d     = cnt_q;
        abort_d   = 1'b0;
        clr       = 1'b0;
        disp_v    = '0;
        retire_v  = '0;
        case (state_q)
            RUN: begin
                if (cnt_q != '1) cnt_d = cnt_q + 21'd1;
                if (|hit_v) begin
                    // Match wins over any retire or dispatch this cycle.
                    cracked_d = win_guess;
                    winner_d  = win_idx;
                    found_d   = 1'b1;
                    done_d    = 1'b1;
                    abort_d   = 1'b1;
                    state_d   = FOUND;
                end else begin
                    retire_v = pe_done_i & busy_v;
                    if (ns_q == 7'(NSLICE) && busy_v == '0) begin
                        done_d  = 1'b1;
                        state_d = EXHAUSTED;
                    end else if (ns_q < 7'(NSLICE) && |free_oh) begin
                        disp_v = free_oh;
                        ns_d   = ns_q + 7'd1;
                    end
                end
            end
            default: begin
                if (start_i) begin
                    clr       = 1'b1;
                    target_d  = password_to_crack_i;
                    found_d   = 1'b0;
                    done_d    = 1'b0;
                    cracked_d = '0;
                    winner_d  = '0;
                    cnt_d     = '0;
                    ns_d      = '0;
                    state_d   = RUN;
                end
            end
        endcase
    end

    // Scheduler state registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            ns_q      <= '0;
            target_q  <= '0;
            found_q   <= 1'b0;
            done_q    <= 1'b0;
            cracked_q <= '0;
            winner_q  <= '0;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ns_q      <= ns_d;
            target_q  <= target_d;
            found_q   <= found_d;
            done_q    <= done_d;
            cracked_q <= cracked_d;
            winner_q  <= winner_d;
            cnt_q     <= cnt_d;
            abort_q   <= abort_d;
        end
    end

    for (genvar g = 0; g < NUM_PE; g++) begin : g_lane
        crack_lane u_lane (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .clr_i    (clr),
            .disp_i   (disp_v[g]),
            .retire_i (retire_v[g]),
            .from_i   (nxt.from),
            .to_i     (nxt.to),
            .busy_o   (busy_v[g]),
            .start_o  (start_v[g]),
            .from_o   (from_a[g]),
            .to_o     (to_a[g])
        );
    end

    assign pe_target_o   = target_q;
    assign pe_start_o    = start_v;
    assign pe_from_o     = from_a;
    assign pe_to_o       = to_a;
    assign pe_abort_o    = abort_q;
    assign busy_o        = (state_q == RUN);
    assign found_o       = found_q;
    assign done_o        = done_q;
    assign cracked_o     = cracked_q;
    assign winner_pe_o   = winner_q;
    assign cycle_count_o = cnt_q;
endmodule

// File: tb/tb_crack_scheduler.sv
// Directed bench: default-sized instance for dispatch/match/reset, and a
// 4-PE / 37-index instance for slice reuse and exhaustion.
module tb_crack_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    // Default instance (9 PEs, 36 indices, slice 4)
    logic         a_start = 1'b0;
    logic [31:0]  a_pwd = '0;
    logic [31:0]  a_target, a_cracked;
    logic [8:0]   a_pe_start, a_found_i, a_done_i;
    logic [53:0]  a_from, a_to;
    logic         a_abort, a_busy, a_found, a_done;
    logic [287:0] a_guess = '0;
    logic [3:0]   a_win;
    logic [20:0]  a_cnt;

    // Small instance (4 PEs, 37 indices, slice 4 -> 10 slices)
    logic         b_start = 1'b0;
    logic [31:0]  b_target, b_cracked;
    logic [3:0]   b_pe_start, b_win;
    logic [3:0]   b_found_i = '0;
    logic [3:0]   b_done_i = '0;
    logic [23:0]  b_from, b_to;
    logic         b_abort, b_busy, b_found, b_done;
    logic [20:0]  b_cnt;

    crack_scheduler u_a (
        .clk_i(clk), .rst_i(rst), .start_i(a_start), .password_to_crack_i(a_pwd),
        .pe_target_o(a_target), .pe_start_o(a_pe_start), .pe_from_o(a_from),
        .pe_to_o(a_to), .pe_abort_o(a_abort), .pe_found_i(a_found_i),
        .pe_done_i(a_done_i), .pe_guess_i(a_guess), .busy_o(a_busy),
        .found_o(a_found), .done_o(a_done), .cracked_o(a_cracked),
        .winner_pe_o(a_win), .cycle_count_o(a_cnt)
    );

    crack_scheduler #(.NUM_PE(4), .CHARSET(37), .SLICE(4), .PWD_W(32)) u_b (
        .clk_i(clk), .rst_i(rst), .start_i(b_start), .password_to_crack_i(32'h0),
        .pe_target_o(b_target), .pe_start_o(b_pe_start), .pe_from_o(b_from),
        .pe_to_o(b_to), .pe_abort_o(b_abort), .pe_found_i(b_found_i),
        .pe_done_i(b_done_i), .pe_guess_i(128'h0), .busy_o(b_busy),
        .found_o(b_found), .done_o(b_done), .cracked_o(b_cracked),
        .winner_pe_o(b_win), .cycle_count_o(b_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int nd;
        int lane;
        int exp_to;
        a_found_i = '0;
        a_done_i  = '0;

        // Reset held with clock running
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   a_busy, 0);
        chk("rst_done",   {a_done, a_found, a_abort}, 0);
        chk("rst_start",  a_pe_start, 0);
        chk("rst_from",   a_from, 0);
        chk("rst_target", a_target, 0);
        chk("rst_cnt",    a_cnt, 0);
        chk("rst_b",      {b_busy, b_done, b_pe_start, b_cnt}, 0);
        rst = 1'b1;
        repeat (3) tick();
        chk("idle_nostart", {a_pe_start, a_busy}, 0);

        // Job start and dispatch order
        a_pwd   = 32'h30303031;
        a_start = 1'b1;
        tick();                                  // edge E
        a_start = 1'b0;
        chk("start_busy",   a_busy, 1);
        chk("start_nopulse", a_pe_start, 0);
        chk("start_target", a_target, 32'h30303031);
        for (int i = 0; i < 9; i++) begin
            tick();                              // edge E+1+i
            chk("disp_onehot", a_pe_start, 64'(1) << i);
            chk("disp_from",   a_from[6*i +: 6], 64'(4 * i));
            chk("disp_to",     a_to[6*i +: 6],   64'(4 * i + 3));
        end
        tick();                                  // E+10: slices used up
        chk("disp_none", a_pe_start, 0);
        chk("held_from8", a_from[48 +: 6], 32);

        // start during RUN is ignored
        a_pwd   = 32'hDEADBEEF;
        a_start = 1'b1;
        tick();                                  // E+11
        a_start = 1'b0;
        a_pwd   = 32'h30303031;
        chk("run_start_ign", a_target, 32'h30303031);
        chk("run_cnt11", a_cnt, 11);

        // Match from PE3, sampled at E+20
        repeat (8) tick();                       // E+19
        a_found_i[3]      = 1'b1;
        a_guess[96 +: 32] = 32'h30303031;
        tick();                                  // E+20
        a_found_i = '0;
        chk("m_found",  {a_found, a_done, a_abort}, 3'b111);
        chk("m_cracked", a_cracked, 32'h30303031);
        chk("m_winner", a_win, 3);
        chk("m_cnt",    a_cnt, 20);
        chk("m_busy",   a_busy, 0);
        tick();
        chk("m_abort_drop", a_abort, 0);
        chk("m_sticky", {a_found, a_done}, 2'b11);
        chk("m_cnt_hold", a_cnt, 20);

        // Simultaneous match: PE5 and PE2 found, PE2 also done
        a_start = 1'b1;
        tick();                                  // E2
        a_start = 1'b0;
        chk("s_clear", {a_found, a_done, a_cnt}, 0);
        repeat (9) tick();                       // all 9 PEs busy
        a_found_i[5] = 1'b1;
        a_found_i[2] = 1'b1;
        a_done_i[2]  = 1'b1;
        a_guess[64 +: 32]  = 32'hAAAA0002;
        a_guess[160 +: 32] = 32'h55550005;
        tick();                                  // E2+10
        a_found_i = '0;
        a_done_i  = '0;
        chk("s_winner",  a_win, 2);
        chk("s_cracked", a_cracked, 32'hAAAA0002);
        chk("s_found",   {a_found, a_done}, 2'b11);
        chk("s_cnt",     a_cnt, 10);

        // Reset mid-job after three dispatches
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (3) tick();
        chk("r_pre", a_pe_start, 9'b000000100);
        rst = 1'b0;
        #1;
        chk("r_from",  {a_from, a_to}, 0);
        chk("r_outs",  {a_busy, a_pe_start, a_abort, a_done, a_found}, 0);
        chk("r_misc",  {a_target, a_cnt, a_win}, 0);
        repeat (2) tick();
        chk("r_noabort", a_abort, 0);
        rst = 1'b1;
        tick();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        chk("r_redisp", a_pe_start, 1);
        chk("r_from0",  {a_from[0 +: 6], a_to[0 +: 6]}, {6'd0, 6'd3});
        chk("r_cnt",    a_cnt, 1);

        // Exhaustion with reuse on the small instance: each dispatched PE
        // retires on the next cycle, so slots 0 and 1 alternate.
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        nd = 0;
        for (int c = 0; c < 40 && !b_done; c++) begin
            tick();
            b_done_i = '0;
            if (b_pe_start != 0) begin
                lane   = nd % 2;
                exp_to = (4 * nd + 3 > 36) ? 36 : 4 * nd + 3;
                chk("x_onehot", b_pe_start, 64'(1) << lane);
                chk("x_from",   b_from[6*lane +: 6], 64'(4 * nd));
                chk("x_to",     b_to[6*lane +: 6],   64'(exp_to));
                b_done_i = b_pe_start;
                nd++;
            end
        end
        chk("x_count", nd, 10);
        chk("x_done",  {b_done, b_found, b_busy}, 3'b100);
        chk("x_cnt",   b_cnt, 12);
        chk("x_noabort", b_abort, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
